// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issue-side controller for the 64-bit iterative divider core (RV64M DIV/REM + W forms).
// Build option: define DIV_RESULT_CACHE_EN to keep the last core result and serve a matching DIV/REM pair in one cycle.
module div_issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid_i,
  output logic        issue_ready_o,
  input  logic [1:0]  op_i,
  input  logic        word_i,
  input  logic [63:0] rs1_i,
  input  logic [63:0] rs2_i,
  input  logic        flush_i,
  output logic        result_valid_o,
  input  logic        result_ready_i,
  output logic [63:0] result_o,
  output logic        div_req_valid_o,
  output logic        div_block_o,
  output logic [63:0] div_op_1_o,
  output logic [63:0] div_op_2_o,
  output logic        div_sign_1_o,
  output logic        div_sign_2_o,
  input  logic [63:0] div_quotient_i,
  input  logic [63:0] div_remainder_i,
  input  logic        div_ready_i,
  input  logic        div_valid_i
);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DRAIN, DONE} state_t;

  localparam logic [63:0] MIN64    = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MIN32_SX = 64'hFFFF_FFFF_8000_0000;

  state_t      state_q, state_d;
  logic        rem_q, word_q, signed_q;
  logic [63:0] op1_q, op2_q, result_q;

  logic        sgn_in, accept, capture, div_zero, overflow, special, cache_hit;
  logic [63:0] fmt_1, fmt_2, spec_quot, spec_rem, hit_quot, hit_rem;

  function automatic logic [63:0] fmt_operand(input logic [63:0] v, input logic word,
                                              input logic sgn);
    return word ? {{32{sgn & v[31]}}, v[31:0]} : v;
  endfunction

  function automatic logic [63:0] select_result(input logic [63:0] quot, input logic [63:0] rem,
                                                input logic use_rem, input logic word);
    logic [63:0] s;
    s = use_rem ? rem : quot;
    return word ? {{32{s[31]}}, s[31:0]} : s;
  endfunction

  // Divide-by-zero and signed overflow never reach the core; they are resolved from the formatted operands.
  always_comb begin
    sgn_in    = ~op_i[0];
    fmt_1     = fmt_operand(rs1_i, word_i, sgn_in);
    fmt_2     = fmt_operand(rs2_i, word_i, sgn_in);
    div_zero  = (fmt_2 == '0);
    overflow  = sgn_in && (fmt_1 == (word_i ? MIN32_SX : MIN64)) && (fmt_2 == '1);
    special   = div_zero | overflow;
    spec_quot = div_zero ? '1 : fmt_1;
    spec_rem  = div_zero ? fmt_1 : '0;
    accept    = issue_valid_i & (state_q == IDLE) & ~flush_i;
    capture   = (state_q == WAIT) & div_valid_i & ~flush_i;
  end

`ifdef DIV_RESULT_CACHE_EN
  logic [63:0] raw1_q, raw2_q, c_rs1_q, c_rs2_q, c_quot_q, c_rem_q;
  logic        c_signed_q, c_word_q, c_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_valid_q <= 1'b0;
    end else if (capture) begin
      c_valid_q <= 1'b1;
    end
  end

  // Key uses the raw register values; only completed core results are stored, never drained ones.
  always_ff @(posedge clk) begin
    if (accept) begin
      raw1_q <= rs1_i;
      raw2_q <= rs2_i;
    end
    if (capture) begin
      c_rs1_q    <= raw1_q;
      c_rs2_q    <= raw2_q;
      c_signed_q <= signed_q;
      c_word_q   <= word_q;
      c_quot_q   <= div_quotient_i;
      c_rem_q    <= div_remainder_i;
    end
  end

  assign cache_hit = c_valid_q && (c_rs1_q == rs1_i) && (c_rs2_q == rs2_i) &&
                     (c_signed_q == sgn_in) && (c_word_q == word_i);
  assign hit_quot  = c_quot_q;
  assign hit_rem   = c_rem_q;
`else
  assign cache_hit = 1'b0;
  assign hit_quot  = '0;
  assign hit_rem   = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Flush outranks accept and result_ready; flushes arriving in DRAIN change nothing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (special || cache_hit) ? DONE : LAUNCH;
      LAUNCH:  if (flush_i) state_d = IDLE;
               else if (div_ready_i) state_d = WAIT;
      WAIT:    if (flush_i) state_d = DRAIN;
               else if (div_valid_i) state_d = DONE;
      DRAIN:   if (div_valid_i) state_d = IDLE;
      DONE:    if (flush_i || result_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    issue_ready_o   = (state_q == IDLE);
    result_valid_o  = (state_q == DONE);
    div_block_o     = (state_q == IDLE) || (state_q == DONE);
    div_req_valid_o = (state_q == LAUNCH) && div_ready_i && !flush_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q    <= 1'b0;
      word_q   <= 1'b0;
      signed_q <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      rem_q    <= op_i[1];
      word_q   <= word_i;
      signed_q <= sgn_in;
      op1_q    <= fmt_1;
      op2_q    <= fmt_2;
      if (special)        result_q <= select_result(spec_quot, spec_rem, op_i[1], word_i);
      else if (cache_hit) result_q <= select_result(hit_quot, hit_rem, op_i[1], word_i);
    end else if (capture) begin
      result_q <= select_result(div_quotient_i, div_remainder_i, rem_q, word_q);
    end
  end

  assign result_o     = result_q;
  assign div_op_1_o   = op1_q;
  assign div_op_2_o   = op2_q;
  assign div_sign_1_o = signed_q;
  assign div_sign_2_o = signed_q;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: randomized bench for div_issue_ctrl with a behavioural divider core and a
// cycle-level reference model of the controller; follows DIV_RESULT_CACHE_EN when defined.
module tb_div_issue_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        issue_valid_i = 1'b0, issue_ready_o;
  logic [1:0]  op_i = '0;
  logic        word_i = 1'b0;
  logic [63:0] rs1_i = '0, rs2_i = '0;
  logic        flush_i = 1'b0, result_valid_o, result_ready_i = 1'b0;
  logic [63:0] result_o;
  logic        div_req_valid_o, div_block_o, div_sign_1_o, div_sign_2_o;
  logic [63:0] div_op_1_o, div_op_2_o, div_quotient_i, div_remainder_i;
  logic        div_ready_i, div_valid_i;

`ifdef DIV_RESULT_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif
  localparam logic signed [31:0] MIN32 = 32'sh8000_0000;
  localparam logic signed [63:0] MIN64 = 64'sh8000_0000_0000_0000;
  localparam int M_IDLE = 0, M_BUSY = 1, M_DRAIN = 2, M_VALID = 3;

  always #5 clk = ~clk;

  div_issue_ctrl dut (
    .clk(clk), .rst(rst), .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .op_i(op_i), .word_i(word_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .result_o(result_o),
    .div_req_valid_o(div_req_valid_o), .div_block_o(div_block_o),
    .div_op_1_o(div_op_1_o), .div_op_2_o(div_op_2_o),
    .div_sign_1_o(div_sign_1_o), .div_sign_2_o(div_sign_2_o),
    .div_quotient_i(div_quotient_i), .div_remainder_i(div_remainder_i),
    .div_ready_i(div_ready_i), .div_valid_i(div_valid_i)
  );

  int tests = 0, fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RISC-V M-extension result from the raw instruction operands.
  function automatic logic [63:0] ref_res(input logic [1:0] op, input logic word,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] wa, wb;
    logic [63:0] r;
    logic [31:0] w;
    sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; r = '0; w = '0;
    if (word) begin
      case (op)
        2'b00:   if (wb == 0) w = '1; else if (wa == MIN32 && wb == -1) w = wa; else w = wa / wb;
        2'b01:   if (b[31:0] == 0) w = '1; else w = a[31:0] / b[31:0];
        2'b10:   if (wb == 0) w = wa; else if (wa == MIN32 && wb == -1) w = '0; else w = wa % wb;
        default: if (b[31:0] == 0) w = a[31:0]; else w = a[31:0] % b[31:0];
      endcase
      r = {{32{w[31]}}, w};
    end else begin
      case (op)
        2'b00:   if (sb == 0) r = '1; else if (sa == MIN64 && sb == -1) r = sa; else r = sa / sb;
        2'b01:   if (b == 0) r = '1; else r = a / b;
        2'b10:   if (sb == 0) r = sa; else if (sa == MIN64 && sb == -1) r = '0; else r = sa % sb;
        default: if (b == 0) r = a; else r = a % b;
      endcase
    end
    return r;
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic word,
                                    input logic [63:0] a, input logic [63:0] b);
    bit sg;
    sg = !op[0];
    if (word) return (b[31:0] == 0) || (sg && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 0) || (sg && a == 64'h8000_0000_0000_0000 && b == '1);
  endfunction

  function automatic logic [127:0] core_div(input logic [63:0] a, input logic [63:0] b, input logic sg);
    if (b == 0) return {64'hFFFF_FFFF_FFFF_FFFF, a};
    if (sg && a == 64'h8000_0000_0000_0000 && b == '1) return {a, 64'h0};
    if (sg) return {64'($signed(a) / $signed(b)), 64'($signed(a) % $signed(b))};
    return {a / b, a % b};
  endfunction

  // Divider core: idles with valid/ready high, busy 65 cycles after a request, frozen by block.
  int ccnt = 0, req_count = 0;
  logic [63:0] cq = '0, cr = '0;
  assign div_ready_i     = (ccnt == 0);
  assign div_valid_i     = (ccnt == 0);
  assign div_quotient_i  = cq;
  assign div_remainder_i = cr;
  always @(posedge clk) begin
    if (rst) begin
      ccnt <= 0; cq <= '0; cr <= '0;
    end else if (!div_block_o) begin
      if (ccnt == 0 && div_req_valid_o) begin
        ccnt <= 65;
        {cq, cr} <= core_div(div_op_1_o, div_op_2_o, div_sign_1_o);
        req_count <= req_count + 1;
      end else if (ccnt != 0) begin
        ccnt <= ccnt - 1;
      end
    end
  end

  // Reference model: phase plus cycle arithmetic relative to the accept cycle.
  int mph = M_IDLE, cyc = 0, m_acc = 0;
  logic [63:0] m_res = '0, m_rs1 = '0, m_rs2 = '0, mc_rs1 = '0, mc_rs2 = '0;
  logic m_sg = 1'b0, m_wd = 1'b0, mc_sg = 1'b0, mc_wd = 1'b0, mc_valid = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      mph <= M_IDLE; mc_valid <= 1'b0;
    end else begin
      case (mph)
        M_IDLE: if (issue_valid_i && !flush_i) begin
          m_res <= ref_res(op_i, word_i, rs1_i, rs2_i);
          m_acc <= cyc; m_rs1 <= rs1_i; m_rs2 <= rs2_i; m_sg <= !op_i[0]; m_wd <= word_i;
          if (is_special(op_i, word_i, rs1_i, rs2_i) ||
              (CACHE_EN && mc_valid && mc_rs1 == rs1_i && mc_rs2 == rs2_i &&
               mc_sg == !op_i[0] && mc_wd == word_i)) mph <= M_VALID;
          else mph <= M_BUSY;
        end
        M_BUSY: if (flush_i) mph <= (cyc == m_acc + 1) ? M_IDLE : M_DRAIN;
                else if (cyc == m_acc + 67) begin
                  mph <= M_VALID; mc_valid <= 1'b1;
                  mc_rs1 <= m_rs1; mc_rs2 <= m_rs2; mc_sg <= m_sg; mc_wd <= m_wd;
                end
        M_DRAIN: if (cyc == m_acc + 67) mph <= M_IDLE;
        default: if (flush_i || result_ready_i) mph <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("issue_ready", 64'(issue_ready_o), 64'(mph == M_IDLE));
      check("result_valid", 64'(result_valid_o), 64'(mph == M_VALID));
      check("div_block", 64'(div_block_o), 64'(mph == M_IDLE || mph == M_VALID));
      check("div_req_valid", 64'(div_req_valid_o),
            64'(mph == M_BUSY && cyc == m_acc + 1 && !flush_i));
      if (mph == M_VALID) check("result", result_o, m_res);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!issue_ready_o && n < 200) begin step(); n++; end
    if (!issue_ready_o) begin
      tests++; fails++;
      $display("FAIL wait_idle: issue_ready_o=0 after %0d cycles, expected 1", n);
    end
  endtask

  // mode 0: take result, 1: flush at accept+f, 2: flush in DONE, 3: reset at accept+f
  task automatic do_op(input logic [1:0] op, input logic word, input logic [63:0] a,
                       input logic [63:0] b, input int mode, input int f, input int hold,
                       input int exp_lat, input int exp_reqs);
    int t0, n, reqs0;
    bit quick;
    wait_idle();
    op_i = op; word_i = word; rs1_i = a; rs2_i = b; issue_valid_i = 1'b1;
    t0 = cyc; reqs0 = req_count;
    step();
    issue_valid_i = 1'b0;
    quick = (mph == M_VALID);
    if (mode == 1 || mode == 3) begin
      while (cyc < t0 + f) step();
      if (mode == 1) flush_i = 1'b1; else rst = 1'b1;
      step();
      flush_i = 1'b0; rst = 1'b0;
      if (mode == 3) check("reset_idle", 64'(issue_ready_o), 64'd1);
      else begin
        wait_idle();
        check("flush_release", 64'(cyc - t0), 64'(quick ? f + 1 : (f == 1 ? 2 : 68)));
      end
    end else begin
      n = 0;
      while (!result_valid_o && n < 100) begin step(); n++; end
      if (!result_valid_o) begin
        tests++; fails++;
        $display("FAIL result_timeout: result_valid_o=0 after %0d cycles, expected 1", n);
      end else begin
        if (exp_lat >= 0) check("latency", 64'(cyc - t0), 64'(exp_lat));
        repeat (hold) begin
          issue_valid_i = 1'($urandom % 2); rs1_i = {$urandom, $urandom}; step();
        end
        issue_valid_i = 1'b0;
        if (mode == 2) flush_i = 1'b1; else result_ready_i = 1'b1;
        step();
        flush_i = 1'b0; result_ready_i = 1'b0;
        if (exp_reqs >= 0) check("core_requests", 64'(req_count - reqs0), 64'(exp_reqs));
      end
    end
  endtask

  function automatic logic [63:0] pick();
    case ($urandom % 8)
      0: return 64'h0;
      1: return 64'h1;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'hFFFF_FFFF_8000_0000;
      5: return 64'h0000_0000_8000_0000;
      6: return {$urandom, $urandom};
      default: return 64'($urandom % 100);
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached with %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int md, r;
    repeat (3) step();
    check("rst_issue_ready", 64'(issue_ready_o), 64'd1);
    check("rst_result_valid", 64'(result_valid_o), 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_req", 64'(div_req_valid_o), 64'd0);
    check("rst_block", 64'(div_block_o), 64'd1);
    check("rst_op1", div_op_1_o, 64'd0);
    check("rst_op2", div_op_2_o, 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    check("pin_div", ref_res(2'b00, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9), 64'hFFFF_FFFF_FFFF_FFF2);
    check("pin_rem", ref_res(2'b10, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9), 64'd2);
    check("pin_divu0", ref_res(2'b01, 1'b0, 64'h1234, 64'd0), 64'hFFFF_FFFF_FFFF_FFFF);
    check("pin_remu0", ref_res(2'b11, 1'b0, 64'h1234, 64'd0), 64'h1234);
    check("pin_divw_ovf", ref_res(2'b00, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF), 64'hFFFF_FFFF_8000_0000);
    check("pin_remw_ovf", ref_res(2'b10, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF), 64'd0);
    check("pin_divu", ref_res(2'b01, 1'b0, 64'd1000, 64'd7), 64'd142);
    check("pin_remu", ref_res(2'b11, 1'b0, 64'd1000, 64'd7), 64'd6);

    do_op(2'b00, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 0, 0, 0, 68, 1);
    do_op(2'b10, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 0, 0, 0, CACHE_EN ? 1 : 68, CACHE_EN ? 0 : 1);
    do_op(2'b01, 1'b0, 64'h1234, 64'd0, 0, 0, 0, 1, 0);
    do_op(2'b11, 1'b0, 64'h1234, 64'd0, 0, 0, 0, 1, 0);
    do_op(2'b00, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 0, 0, 0, 1, 0);
    do_op(2'b10, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 0, 0, 0, 1, 0);
    do_op(2'b00, 1'b0, 64'd555, 64'd3, 1, 12, 0, -1, -1);
    do_op(2'b00, 1'b0, 64'd555, 64'd4, 1, 1, 0, -1, -1);
    do_op(2'b01, 1'b0, 64'd77, 64'd5, 0, 0, 5, 68, 1);
    do_op(2'b01, 1'b0, 64'd1000, 64'd7, 0, 0, 0, 68, 1);
    do_op(2'b11, 1'b0, 64'd1000, 64'd7, 0, 0, 0, CACHE_EN ? 1 : 68, CACHE_EN ? 0 : 1);
    do_op(2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FF00, 64'd9, 2, 0, 2, 68, 1);
    do_op(2'b10, 1'b0, 64'd12345, 64'd11, 3, 30, 0, -1, -1);

    for (int i = 0; i < 40; i++) begin
      if ($urandom % 8 == 0) begin
        wait_idle();
        issue_valid_i = 1'b1; flush_i = 1'b1; step();
        issue_valid_i = 1'b0; flush_i = 1'b0;
      end
      r = int'($urandom % 20);
      md = (r < 14) ? 0 : (r < 16) ? 1 : (r < 18) ? 2 : 3;
      do_op(2'($urandom), 1'($urandom), pick(), pick(), md,
            (md == 3) ? 1 + int'($urandom % 70) : 1 + int'($urandom % 60),
            int'($urandom % 4), -1, -1);
    end
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
